// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB3 completer backed by a word-addressed register memory. Each transfer is
// latched on its setup phase, held for a configurable number of wait states and
// then answered with PREADY. Misaligned or out-of-range accesses complete with
// PSLVERR=1, return zero read data and leave the memory untouched.
//
// Parameters
//   ADDR_WIDTH  : PADDR width in bits (byte address)
//   DATA_WIDTH  : PWDATA / PRDATA width in bits
//   MEM_DEPTH   : number of DATA_WIDTH words, at most 2^(ADDR_WIDTH-2)
//   WAIT_STATES : extra access-phase cycles before PREADY (0..15)
//
// Ports
//   PCLK    in   clock, all state changes on the rising edge
//   RESETn  in   asynchronous active-low reset (also clears the memory)
//   PSEL    in   slave select
//   PENABLE in   access-phase indicator
//   PWRITE  in   1 = write, 0 = read
//   PADDR   in   byte address
//   PWDATA  in   write data
//   PRDATA  out  read data, non-zero only with PREADY on an error-free read
//   PREADY  out  registered transfer completion
//   PSLVERR out  error response, only meaningful with PREADY
// -----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  RESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Word index width of the full address and of the physical memory.
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // One extra bit so MEM_DEPTH == 2^WORD_W is still representable.
    localparam logic [WORD_W:0] DEPTH_LIM = (WORD_W + 1)'(MEM_DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

    // -------------------------------------------------------------------------
    // Address decode helpers
    // -------------------------------------------------------------------------
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [WORD_W:0] word;
        word = {1'b0, a[ADDR_WIDTH-1:2]};
        return (a[1:0] != 2'b00) || (word >= DEPTH_LIM);
    endfunction

    function automatic logic [IDX_W-1:0] mem_index(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    // Read data is only returned for an error-free read; everything else is 0.
    function automatic logic [DATA_WIDTH-1:0] resp_data(
        input logic                  wr,
        input logic                  err,
        input logic [DATA_WIDTH-1:0] word
    );
        return (wr || err) ? '0 : word;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;

    // Setup-phase snapshot; access-phase address/data changes are ignored.
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;

    logic                  ready_next;
    logic                  slverr_next;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic                  latch_setup;
    logic                  commit_write;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Live decode of the bus (zero-wait-state response) and of the snapshot.
    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;
    logic [IDX_W-1:0]      held_idx;
    logic [DATA_WIDTH-1:0] setup_word;
    logic [DATA_WIDTH-1:0] held_word;

    assign setup_err  = addr_err(PADDR);
    assign setup_idx  = mem_index(PADDR);
    assign held_idx   = mem_index(addr_q);
    assign setup_word = mem[setup_idx];
    assign held_word  = mem[held_idx];

    // -------------------------------------------------------------------------
    // Next-state / response logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ready_next   = PREADY;
        slverr_next  = PSLVERR;
        rdata_next   = PRDATA;
        latch_setup  = 1'b0;
        commit_write = 1'b0;

        case (state)
            ST_IDLE: begin
                // PSEL with PENABLE already high in IDLE is a protocol
                // violation and is simply ignored.
                if (PSEL && !PENABLE) begin
                    latch_setup = 1'b1;
                    state_next  = ST_ACCESS;
                    cnt_next    = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        // No wait states: answer straight from the bus values
                        // that are being latched on this edge.
                        ready_next  = 1'b1;
                        slverr_next = setup_err;
                        rdata_next  = resp_data(PWRITE, setup_err, setup_word);
                    end
                end
            end

            ST_ACCESS: begin
                if (!PREADY) begin
                    if (!PSEL) begin
                        // Master gave up before completion: nothing commits.
                        state_next = ST_IDLE;
                        cnt_next   = 4'd0;
                    end else if (cnt > 4'd1) begin
                        cnt_next = cnt - 4'd1;
                    end else begin
                        cnt_next    = 4'd0;
                        ready_next  = 1'b1;
                        slverr_next = err_q;
                        rdata_next  = resp_data(write_q, err_q, held_word);
                    end
                end else if (!PSEL || PENABLE) begin
                    // Completion (PSEL & PENABLE) or abort (PSEL low); only a
                    // genuine completion of a valid write touches memory.
                    commit_write = PSEL && write_q && !err_q;
                    state_next   = ST_IDLE;
                    cnt_next     = 4'd0;
                    ready_next   = 1'b0;
                    slverr_next  = 1'b0;
                    rdata_next   = '0;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                cnt_next    = 4'd0;
                ready_next  = 1'b0;
                slverr_next = 1'b0;
                rdata_next  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            PREADY  <= ready_next;
            PSLVERR <= slverr_next;
            PRDATA  <= rdata_next;
        end
    end

    // -------------------------------------------------------------------------
    // Setup-phase snapshot (pure data, only meaningful while in ACCESS)
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (latch_setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= setup_err;
        end
    end

    // -------------------------------------------------------------------------
    // Register memory: cleared by reset, written on the completion edge
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_write) begin
            mem[held_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int WS    = 1;

    logic          PCLK    = 1'b0;
    logic          RESETn  = 1'b0;
    logic          PSEL    = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE  = 1'b0;
    logic [AW-1:0] PADDR   = '0;
    logic [DW-1:0] PWDATA  = '0;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_slave_mem #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .PCLK   (PCLK),
        .RESETn (RESETn),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic          wr;
        logic          err;
        logic [DW-1:0] rdata;
    } resp_t;

    resp_t         sb_q[$];
    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] last_rdata;
    logic          last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic exp_err(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || (int'(a[AW-1:2]) >= DEPTH);
    endfunction

    task automatic model_clear();
        foreach (model[i]) model[i] = '0;
    endtask

    // Full transfer starting just after a rising edge; returns just after the
    // completion edge with PSEL/PENABLE low so another call is back-to-back.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        resp_t e;
        resp_t got;
        int    waits;
        int    idx;
        logic  er;
        er      = exp_err(a);
        idx     = int'(a[AW-1:2]);
        e.wr    = wr;
        e.err   = er;
        e.rdata = '0;
        if (!wr && !er) e.rdata = model[idx];
        sb_q.push_back(e);

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        // Scramble address/data during access; the slave must use latched values.
        PADDR  = ~a;
        PWDATA = ~d;
        waits  = 0;
        while (!PREADY && waits < 40) begin
            check("wait_pslverr", 32'(PSLVERR), 32'd0);
            check("wait_prdata", PRDATA, 32'd0);
            @(posedge PCLK); #1;
            waits++;
        end
        if (!PREADY) begin
            check("pready_timeout", 32'(PREADY), 32'd1);
            void'(sb_q.pop_front());
        end else begin
            check("wait_states", 32'(waits), 32'(WS));
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                got = sb_q.pop_front();
                check("pslverr", 32'(PSLVERR), 32'(got.err));
                check("prdata", PRDATA, got.rdata);
            end
            last_rdata = PRDATA;
            last_err   = PSLVERR;
            @(posedge PCLK); #1;
            if (wr && !er) model[idx] = d;
            check("done_pready", 32'(PREADY), 32'd0);
            check("done_pslverr", 32'(PSLVERR), 32'd0);
            check("done_prdata", PRDATA, 32'd0);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge PCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          wr;
        logic [AW-1:0] a;
        model_clear();

        // Reset held for 3 cycles
        RESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        RESETn = 1'b1;
        idle_cycle();
        apb_xfer(1'b0, 8'h00, '0);
        check("rst_read00", last_rdata, 32'h0000_0000);

        // Write then read
        apb_xfer(1'b1, 8'h04, 32'hDEAD_BEEF);
        check("wr04_err", 32'(last_err), 32'd0);
        apb_xfer(1'b0, 8'h04, '0);
        check("rd04_data", last_rdata, 32'hDEAD_BEEF);

        // Error responses
        apb_xfer(1'b1, 8'h80, 32'h1234_5678);
        check("wr80_err", 32'(last_err), 32'd1);
        apb_xfer(1'b0, 8'h06, '0);
        check("rd06_err", 32'(last_err), 32'd1);
        check("rd06_data", last_rdata, 32'd0);
        apb_xfer(1'b0, 8'h00, '0);
        check("rd00_unchanged", last_rdata, 32'd0);

        // Back-to-back write/read
        apb_xfer(1'b1, 8'h7C, 32'hA5A5_A5A5);
        check("b2b_wr_err", 32'(last_err), 32'd0);
        apb_xfer(1'b0, 8'h7C, '0);
        check("b2b_rd_err", 32'(last_err), 32'd0);
        check("b2b_rd_data", last_rdata, 32'hA5A5_A5A5);
        idle_cycle();

        // Abort before PREADY
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'hFFFF_FFFF;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("abort_pready1", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        check("abort_pready2", 32'(PREADY), 32'd0);
        apb_xfer(1'b0, 8'h08, '0);
        check("abort_rd08", last_rdata, 32'd0);

        // PSEL+PENABLE in IDLE is ignored
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h14; PWDATA = 32'h0F0F_0F0F;
        repeat (2) begin
            @(posedge PCLK); #1;
            check("proto_pready", 32'(PREADY), 32'd0);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        apb_xfer(1'b0, 8'h14, '0);
        check("proto_rd14", last_rdata, 32'd0);

        // Reset during the wait state of a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h0BAD_F00D;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 RESETn = 1'b0;
        #1 check("midrst_pready", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        check("midrst_hold_pready", 32'(PREADY), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        #2 RESETn = 1'b1;
        model_clear();
        idle_cycle();
        apb_xfer(1'b0, 8'h0C, '0);
        check("midrst_rd0c", last_rdata, 32'd0);
        apb_xfer(1'b0, 8'h04, '0);
        check("midrst_rd04_cleared", last_rdata, 32'd0);

        // Asynchronous reset while PREADY is high drops outputs at once
        apb_xfer(1'b1, 8'h10, 32'h0000_0055);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h10;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check("arst_pre_pready", 32'(PREADY), 32'd1);
        check("arst_pre_prdata", PRDATA, 32'h0000_0055);
        #2 RESETn = 1'b0;
        #1;
        check("arst_pready", 32'(PREADY), 32'd0);
        check("arst_prdata", PRDATA, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        #2 RESETn = 1'b1;
        model_clear();
        idle_cycle();

        // Random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 8'h8F));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            apb_xfer(wr, a, $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer (slave) that sits directly downstream of the APB bus interface and consumes the PSEL/PENABLE/PWRITE/PADDR/PWDATA phases it drives.
- Provides a word-addressed register memory with a parameterised number of wait states.
- Signals PSLVERR for misaligned or out-of-range accesses.
- Serves as the DUT target for the UVM master agent.

Parameters:
ADDR_WIDTH, 8, PADDR width in bits (byte address)
DATA_WIDTH, 32, PWDATA/PRDATA width in bits
MEM_DEPTH, 32, number of DATA_WIDTH words; must be at most 2^(ADDR_WIDTH-2)
WAIT_STATES, 1, extra access-phase cycles before PREADY is asserted (0..15)

Ports:
PCLK  input  1  clock, all state updates on the rising edge
RESETn  input  1  asynchronous active-low reset
PSEL  input  1  slave select
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_WIDTH  byte address
PWDATA  input  DATA_WIDTH  write data
PRDATA  output  DATA_WIDTH  read data, valid only with PREADY=1 and a read transfer
PREADY  output  1  transfer completion, registered
PSLVERR  output  1  error response, valid only with PREADY=1

Behaviour:
- Reset (RESETn=0, asynchronous):
  - state=IDLE, wait counter=0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - All memory words cleared to 0.
  - Reset asserted mid-transfer aborts the transfer, and a pending write is not committed.
- Index and error rules:
  - idx = PADDR[ADDR_WIDTH-1:2].
  - err = (PADDR[1:0] != 0) OR (idx >= MEM_DEPTH).
  - err is evaluated on the latched setup-phase address.
- FSM states: IDLE, ACCESS.
- IDLE:
  - At a rising edge with PSEL=1 and PENABLE=0: latch PADDR, PWRITE, PWDATA and err; cnt <= WAIT_STATES; go to ACCESS.
  - If WAIT_STATES=0, assert PREADY on the same edge and load the response (see below).
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol error: ignore it and stay in IDLE.
- ACCESS, PREADY=0:
  - If PSEL=0: abort, go to IDLE, no write.
  - Else if cnt>1: cnt decrements.
  - Else (cnt==1): cnt <= 0, assert PREADY and load the response.
- Response load (applies when PREADY is asserted):
  - PSLVERR <= err.
  - PRDATA <= mem[idx] for a read with no error; PRDATA <= 0 for a write or on error.
- ACCESS, PREADY=1, at the next edge with PSEL=1 and PENABLE=1 (transfer completes):
  - If PWRITE and !err, mem[idx] <= latched PWDATA.
  - PREADY, PSLVERR and PRDATA return to 0; go to IDLE.
  - A write commits on this completion edge; reading the same word in the next transfer returns the new value.
- ACCESS, PREADY=1, with PSEL=0 at that edge: treat as abort; outputs return to 0, go to IDLE, no write.
- Latency:
  - PREADY rises WAIT_STATES edges after the first access-phase cycle begins, so the minimum transfer is 2 cycles and a transfer takes 2+WAIT_STATES cycles.
  - Back-to-back transfers: the slave is back in IDLE on the completion edge and samples the master's next setup phase at the following edge. No idle cycle is required between transfers.
- Error transfers:
  - PREADY timing is the same as for a valid transfer.
  - Memory is unchanged and PRDATA=0.
- Address and write-data changes during the access phase are ignored; latched values are used.
- PSLVERR and PRDATA are 0 whenever PREADY=0.

Test Plan:
- Reset: hold RESETn=0 for 3 cycles, then release -> PREADY=0, PSLVERR=0, PRDATA=0; a read of 0x00 returns 0x00000000.
- Write then read, WAIT_STATES=1:
  - Write 0xDEADBEEF to 0x04 -> PREADY high in the 2nd access cycle, PSLVERR=0.
  - Read 0x04 -> PRDATA=0xDEADBEEF with PREADY; total 3 cycles per transfer.
- Errors, MEM_DEPTH=32:
  - Write 0x12345678 to 0x80 -> PSLVERR=1 with PREADY.
  - Read 0x06 (misaligned) -> PSLVERR=1, PRDATA=0.
  - Read 0x00 afterwards -> unchanged value.
- Back-to-back: write 0xA5A5A5A5 to 0x7C immediately followed by a read of 0x7C (no idle cycle) -> read returns 0xA5A5A5A5 and both transfers complete with PSLVERR=0.
- Abort: drive a setup phase for a write of 0xFFFFFFFF to 0x08, then drop PSEL in the access phase before PREADY -> slave returns to IDLE and a later read of 0x08 returns the prior value (0).
- Reset mid-transfer: pulse RESETn low during the wait state of a write to 0x0C -> PREADY=0 immediately, and a read of 0x0C after release returns 0.
